// File: rtl/demux_deserializer.sv
// Per-channel bit-stream deserializer behind a 1-to-4 demux, with round-robin output arbitration.
// Optional even-parity framing is enabled by defining DEMUX_DESER_PARITY_EN (adds out_perr).
module demux_deserializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s0,
  input  logic              s1,
  input  logic              d0,
  input  logic              d1,
  input  logic              d2,
  input  logic              d3,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_chan,
  output logic              out_valid,
  output logic [3:0]        ovf
`ifdef DEMUX_DESER_PARITY_EN
  ,
  output logic              out_perr
`endif
);

`ifdef DEMUX_DESER_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
  localparam int SH_W    = DATA_W;
`else
  localparam int FRAME_W = DATA_W;
  // The final bit is taken straight from the input, so only DATA_W-1 bits are stored.
  localparam int SH_W    = DATA_W - 1;
`endif
  localparam int              CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  logic [SH_W-1:0]   shreg [4];
  logic [CNT_W-1:0]  cnt   [4];
  logic [DATA_W-1:0] hold  [4];
  logic [3:0]        hold_v;
  logic [1:0]        ptr;

  logic [1:0]        sel;
  logic [3:0]        d_vec;
  logic              bit_in;
  logic              last_bit;
  logic [DATA_W-1:0] word_data;
  logic              load;
  logic              gnt_v;
  logic [1:0]        gnt;
  logic [1:0]        idx;
  logic              drain_sel;

`ifdef DEMUX_DESER_PARITY_EN
  logic [3:0] hold_p;
  logic       word_perr;
  assign word_data = shreg[sel];
  assign word_perr = ^{shreg[sel], bit_in};
`else
  assign word_data = {shreg[sel], bit_in};
`endif

  assign sel      = {s0, s1};
  assign d_vec    = {d3, d2, d1, d0};
  assign bit_in   = d_vec[sel];
  assign last_bit = en && (cnt[sel] == LAST);
  assign load     = !out_valid || out_ready;

  // Search starts one past the last grant; i=4 wraps back onto ptr itself.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_v && hold_v[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign drain_sel = load && gnt_v && (gnt == sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shreg[i] <= '0;
        cnt[i]   <= '0;
        hold[i]  <= '0;
      end
      hold_v    <= '0;
      ptr       <= 2'd3;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ovf       <= '0;
`ifdef DEMUX_DESER_PARITY_EN
      hold_p    <= '0;
      out_perr  <= 1'b0;
`endif
    end else begin
      if (load) begin
        if (gnt_v) begin
          out_data     <= hold[gnt];
          out_chan     <= gnt;
          out_valid    <= 1'b1;
          ptr          <= gnt;
          hold_v[gnt]  <= 1'b0;
`ifdef DEMUX_DESER_PARITY_EN
          out_perr     <= hold_p[gnt];
`endif
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (ovf_clr)
        ovf <= '0;

      if (en) begin
        shreg[sel] <= SH_W'({shreg[sel], bit_in});
        cnt[sel]   <= last_bit ? '0 : cnt[sel] + CNT_W'(1);
      end

      // Later assignments override the drain/clear above when a word lands this cycle.
      if (last_bit) begin
        if (hold_v[sel] && !drain_sel) begin
          ovf[sel] <= 1'b1;
        end else begin
          hold[sel]   <= word_data;
          hold_v[sel] <= 1'b1;
`ifdef DEMUX_DESER_PARITY_EN
          hold_p[sel] <= word_perr;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_deserializer.sv
// Directed self-checking bench for demux_deserializer (DATA_W=8).
// Parity checks are included when DEMUX_DESER_PARITY_EN is defined.
module tb_demux_deserializer;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              s0 = 1'b0;
  logic              s1 = 1'b0;
  logic [3:0]        dv = '0;
  logic              out_ready = 1'b1;
  logic              ovf_clr = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_chan;
  logic              out_valid;
  logic [3:0]        ovf;
`ifdef DEMUX_DESER_PARITY_EN
  logic              out_perr;
`endif

  int total = 0;
  int bad   = 0;

  demux_deserializer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .en(en), .s0(s0), .s1(s1),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .ovf(ovf)
`ifdef DEMUX_DESER_PARITY_EN
    , .out_perr(out_perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put the bit on the selected line and its complement on the others.
  task automatic drive_bit(input logic [1:0] ch, input logic b);
    en = 1'b1;
    {s0, s1} = ch;
    dv = {4{~b}};
    dv[ch] = b;
  endtask

  task automatic idle();
    en = 1'b0;
    dv = '0;
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [DATA_W-1:0] data,
                           input logic perr_flip, input logic clr_last);
    for (int i = DATA_W - 1; i >= 0; i--) begin
`ifndef DEMUX_DESER_PARITY_EN
      if (i == 0) ovf_clr = clr_last;
`endif
      drive_bit(ch, data[i]);
      step();
    end
`ifdef DEMUX_DESER_PARITY_EN
    ovf_clr = clr_last;
    drive_bit(ch, (^data) ^ perr_flip);
    step();
`else
    if (perr_flip) $display("note: parity flip ignored without parity framing");
`endif
    ovf_clr = 1'b0;
    idle();
  endtask

  typedef struct {
    logic [1:0]        ch;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        exp_chan;
  } vec_t;

  vec_t vecs[6];
  int   hs;
  int   vcnt;

  initial begin
    vecs[0] = '{ch: 2'd0, data: 8'hA5, exp_data: 8'hA5, exp_chan: 2'd0};
    vecs[1] = '{ch: 2'd1, data: 8'hFF, exp_data: 8'hFF, exp_chan: 2'd1};
    vecs[2] = '{ch: 2'd2, data: 8'h00, exp_data: 8'h00, exp_chan: 2'd2};
    vecs[3] = '{ch: 2'd3, data: 8'h3C, exp_data: 8'h3C, exp_chan: 2'd3};
    vecs[4] = '{ch: 2'd0, data: 8'h81, exp_data: 8'h81, exp_chan: 2'd0};
    vecs[5] = '{ch: 2'd2, data: 8'h5A, exp_data: 8'h5A, exp_chan: 2'd2};

    // Reset state
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_chan", 32'(out_chan), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Single-word framing on each channel
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].ch, vecs[v].data, 1'b0, 1'b0);
      check($sformatf("vec%0d_latency", v), 32'(out_valid), 32'd0);
      step();
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_chan", v), 32'(out_chan), 32'(vecs[v].exp_chan));
      check($sformatf("vec%0d_ovf", v), 32'(ovf), 32'd0);
      step();
      check($sformatf("vec%0d_drain", v), 32'(out_valid), 32'd0);
    end

    // Interleaving: ch1 streams ones, ch2 streams zeros
    for (int k = 0; k < 2 * DATA_W; k++) begin
      if (k % 2 == 0) drive_bit(2'd1, 1'b1);
      else            drive_bit(2'd2, 1'b0);
      step();
    end
    idle();
    check("il_valid1", 32'(out_valid), 32'd1);
    check("il_chan1", 32'(out_chan), 32'd1);
    check("il_data1", 32'(out_data), 32'hFF);
    step();
    check("il_valid2", 32'(out_valid), 32'd1);
    check("il_chan2", 32'(out_chan), 32'd2);
    check("il_data2", 32'(out_data), 32'h00);
    step();
    check("il_done", 32'(out_valid), 32'd0);

    // Backpressure and overflow on channel 3
    out_ready = 1'b0;
    send_word(2'd3, 8'h3C, 1'b0, 1'b0);
    send_word(2'd3, 8'h3C, 1'b0, 1'b0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data", 32'(out_data), 32'h3C);
    check("bp_ovf_pre", 32'(ovf), 32'd0);
    send_word(2'd3, 8'h3C, 1'b0, 1'b0);
    check("bp_hold_data", 32'(out_data), 32'h3C);
    check("bp_hold_chan", 32'(out_chan), 32'd3);
    check("bp_ovf", 32'(ovf), 32'h8);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 32'd0);
    // Set coinciding with clear must win
    send_word(2'd3, 8'h3C, 1'b0, 1'b1);
    check("bp_set_wins", 32'(ovf), 32'h8);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("bp_ovf_clr2", 32'(ovf), 32'd0);
    out_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid && out_ready) hs++;
      step();
    end
    check("bp_delivered", 32'(hs), 32'd2);

    // Arbitration with all four hold registers full
    out_ready = 1'b0;
    send_word(2'd3, 8'h0F, 1'b0, 1'b0);
    send_word(2'd0, 8'h11, 1'b0, 1'b0);
    send_word(2'd1, 8'h22, 1'b0, 1'b0);
    send_word(2'd2, 8'h44, 1'b0, 1'b0);
    send_word(2'd3, 8'h88, 1'b0, 1'b0);
    check("arb_first_chan", 32'(out_chan), 32'd3);
    check("arb_first_data", 32'(out_data), 32'h0F);
    out_ready = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) vcnt++;
      if (k < 4) begin
        check($sformatf("arb_chan%0d", k), 32'(out_chan), 32'(k));
        check($sformatf("arb_data%0d", k), 32'(out_data), 32'h11 << k);
      end
    end
    check("arb_valid_cycles", 32'(vcnt), 32'd4);

    // Reset in the middle of a word
    out_ready = 1'b0;
    send_word(2'd1, 8'h5A, 1'b0, 1'b0);
    step();
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    for (int i = DATA_W - 1; i >= DATA_W - 4; i--) begin
      drive_bit(2'd0, 1'b1);
      step();
    end
    idle();
    #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_word(2'd0, 8'h81, 1'b0, 1'b0);
    step();
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_data", 32'(out_data), 32'h81);
    check("mid_chan", 32'(out_chan), 32'd0);
    step();
    check("mid_only_one", 32'(out_valid), 32'd0);

`ifdef DEMUX_DESER_PARITY_EN
    send_word(2'd0, 8'hA5, 1'b0, 1'b0);
    step();
    check("par_ok_data", 32'(out_data), 32'hA5);
    check("par_ok_perr", 32'(out_perr), 32'd0);
    step();
    send_word(2'd0, 8'hA5, 1'b1, 1'b0);
    step();
    check("par_bad_data", 32'(out_data), 32'hA5);
    check("par_bad_perr", 32'(out_perr), 32'd1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
